fold_sig_acc: RTL and testbench

- Downstream consumer of the 16-to-8 XOR fold stage.
- Takes one folded byte pair (aa, bb) per accepted beat and builds a rotating-XOR signature of each lane over a frame of FRAME_LEN beats.
- Counts beats where aa differs from bb, then presents the results through a valid/ready output handshake.
- Used as the compaction and compare point after the fold stage in self-check and test paths.

---
 rtl/fold_sig_acc.sv | 110 +++++++++++
 tb/tb_fold_sig_acc.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/fold_sig_acc.sv
// Rotating-XOR signature and mismatch counter over a frame of folded byte pairs.
// Results are presented through a valid/ready handshake once FRAME_LEN beats are accepted.
module fold_sig_acc #(
    parameter int unsigned FRAME_LEN = 16,
    parameter int unsigned CNT_W     = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       aa,
    input  logic [7:0]       bb,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [7:0]       sig_a,
    output logic [7:0]       sig_b,
    output logic [CNT_W-1:0] mismatch_cnt,
    output logic             busy
);

    localparam int unsigned BEAT_W = $clog2(FRAME_LEN + 1);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(FRAME_LEN - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [7:0]        sig_a_q, sig_a_d;
    logic [7:0]        sig_b_q, sig_b_d;
    logic [CNT_W-1:0]  mis_q, mis_d;
    logic [BEAT_W-1:0] beat_q, beat_d;
    logic              in_ready_q, out_valid_q, busy_q;
    logic              accept_c;

    assign accept_c = in_valid & in_ready_q;

    // Next-state and datapath update.
    always_comb begin
        state_d = state_q;
        sig_a_d = sig_a_q;
        sig_b_d = sig_b_q;
        mis_d   = mis_q;
        beat_d  = beat_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    sig_a_d = 8'h00;
                    sig_b_d = 8'h00;
                    mis_d   = '0;
                    beat_d  = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (accept_c) begin
                    sig_a_d = {sig_a_q[6:0], sig_a_q[7]} ^ aa;
                    sig_b_d = {sig_b_q[6:0], sig_b_q[7]} ^ bb;
                    if ((aa != bb) && (mis_q != {CNT_W{1'b1}})) begin
                        mis_d = mis_q + CNT_W'(1);
                    end
                    beat_d = beat_q + BEAT_W'(1);
                    if (beat_q == LAST_BEAT) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Handshake flags are registered from the next state so they align with state_q.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            sig_a_q     <= 8'h00;
            sig_b_q     <= 8'h00;
            mis_q       <= '0;
            beat_q      <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            sig_a_q     <= sig_a_d;
            sig_b_q     <= sig_b_d;
            mis_q       <= mis_d;
            beat_q      <= beat_d;
            in_ready_q  <= (state_d == ST_RUN);
            out_valid_q <= (state_d == ST_DONE);
            busy_q      <= (state_d != ST_IDLE);
        end
    end

    assign in_ready     = in_ready_q;
    assign out_valid    = out_valid_q;
    assign busy         = busy_q;
    assign sig_a        = sig_a_q;
    assign sig_b        = sig_b_q;
    assign mismatch_cnt = mis_q;

endmodule

// File: tb/tb_fold_sig_acc.sv
// Directed bench for fold_sig_acc: three instances cover frame lengths 4 and 2
// and a 2-bit saturating mismatch counter.
module tb_fold_sig_acc;

    logic clk;
    logic rst;

    // Instance A: FRAME_LEN=4, CNT_W=5
    logic       a_start, a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_busy;
    logic [7:0] a_aa, a_bb, a_sig_a, a_sig_b;
    logic [4:0] a_mis;
    // Instance B: FRAME_LEN=2, CNT_W=5
    logic       b_start, b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_busy;
    logic [7:0] b_aa, b_bb, b_sig_a, b_sig_b;
    logic [4:0] b_mis;
    // Instance C: FRAME_LEN=4, CNT_W=2
    logic       c_start, c_in_valid, c_in_ready, c_out_valid, c_out_ready, c_busy;
    logic [7:0] c_aa, c_bb, c_sig_a, c_sig_b;
    logic [1:0] c_mis;

    int n_checks = 0;
    int n_fail   = 0;

    fold_sig_acc #(.FRAME_LEN(4), .CNT_W(5)) u_dut_a (
        .clk(clk), .rst(rst), .start(a_start), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .aa(a_aa), .bb(a_bb), .out_valid(a_out_valid), .out_ready(a_out_ready),
        .sig_a(a_sig_a), .sig_b(a_sig_b), .mismatch_cnt(a_mis), .busy(a_busy)
    );

    fold_sig_acc #(.FRAME_LEN(2), .CNT_W(5)) u_dut_b (
        .clk(clk), .rst(rst), .start(b_start), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .aa(b_aa), .bb(b_bb), .out_valid(b_out_valid), .out_ready(b_out_ready),
        .sig_a(b_sig_a), .sig_b(b_sig_b), .mismatch_cnt(b_mis), .busy(b_busy)
    );

    fold_sig_acc #(.FRAME_LEN(4), .CNT_W(2)) u_dut_c (
        .clk(clk), .rst(rst), .start(c_start), .in_valid(c_in_valid), .in_ready(c_in_ready),
        .aa(c_aa), .bb(c_bb), .out_valid(c_out_valid), .out_ready(c_out_ready),
        .sig_a(c_sig_a), .sig_b(c_sig_b), .mismatch_cnt(c_mis), .busy(c_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled 1ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [7:0] g_aa [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    logic [7:0] g_bb [4] = '{8'h11, 8'h00, 8'h33, 8'h00};

    initial begin
        rst = 1'b1;
        {a_start, a_in_valid, a_out_ready, a_aa, a_bb} = '0;
        {b_start, b_in_valid, b_out_ready, b_aa, b_bb} = '0;
        {c_start, c_in_valid, c_out_ready, c_aa, c_bb} = '0;
        #1;
        check("reset_busy",      32'(a_busy), 0);
        check("reset_out_valid", 32'(a_out_valid), 0);
        check("reset_in_ready",  32'(a_in_ready), 0);
        step();
        step();
        rst = 1'b0;
        step();

        // Reset mid-RUN after 2 of 4 beats
        a_start = 1'b1;
        step();
        check("mid_start_in_ready", 32'(a_in_ready), 1);
        a_start = 1'b0;
        a_in_valid = 1'b1; a_aa = 8'h05; a_bb = 8'h06;
        step();
        step();
        check("mid_sig_a_partial", 32'(a_sig_a), 32'h0f);
        check("mid_mis_partial",   32'(a_mis), 2);
        a_in_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst_sig_a",    32'(a_sig_a), 0);
        check("mid_rst_sig_b",    32'(a_sig_b), 0);
        check("mid_rst_mis",      32'(a_mis), 0);
        check("mid_rst_busy",     32'(a_busy), 0);
        check("mid_rst_in_ready", 32'(a_in_ready), 0);
        step();
        rst = 1'b0;
        step();
        check("post_rst_idle", 32'(a_busy), 0);

        // Basic signature: 4 back-to-back beats of 01/01
        a_start = 1'b1;
        step();
        check("basic_in_ready", 32'(a_in_ready), 1);
        check("basic_busy",     32'(a_busy), 1);
        a_start = 1'b0;
        a_in_valid = 1'b1; a_aa = 8'h01; a_bb = 8'h01;
        for (int i = 0; i < 3; i++) begin
            step();
            check("basic_no_early_valid", 32'(a_out_valid), 0);
        end
        step();
        a_in_valid = 1'b0;
        check("basic_out_valid", 32'(a_out_valid), 1);
        check("basic_in_ready_done", 32'(a_in_ready), 0);
        check("basic_sig_a", 32'(a_sig_a), 32'h0f);
        check("basic_sig_b", 32'(a_sig_b), 32'h0f);
        check("basic_mis",   32'(a_mis), 0);

        // Backpressure in DONE with in_valid and start asserted
        a_out_ready = 1'b0; a_in_valid = 1'b1; a_start = 1'b1; a_aa = 8'hFF; a_bb = 8'h00;
        for (int i = 0; i < 5; i++) begin
            step();
            check("bp_out_valid", 32'(a_out_valid), 1);
            check("bp_in_ready",  32'(a_in_ready), 0);
            check("bp_sig_a",     32'(a_sig_a), 32'h0f);
            check("bp_mis",       32'(a_mis), 0);
        end
        a_out_ready = 1'b1; a_in_valid = 1'b0;
        step();
        a_out_ready = 1'b0; a_start = 1'b0;
        check("bp_release_out_valid", 32'(a_out_valid), 0);
        check("bp_release_busy",      32'(a_busy), 0);
        check("bp_hold_sig_a",        32'(a_sig_a), 32'h0f);
        check("bp_hold_sig_b",        32'(a_sig_b), 32'h0f);
        step();
        check("no_restart_on_exit", 32'(a_busy), 0);

        // Gapped input with mismatches on beats 2 and 4
        a_start = 1'b1;
        step();
        a_start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            a_in_valid = 1'b1; a_aa = g_aa[i]; a_bb = g_bb[i];
            step();
            a_in_valid = 1'b0; a_aa = 8'hFF; a_bb = 8'h00;
            if (i < 3) check("gap_no_early_valid", 32'(a_out_valid), 0);
            else       check("gap_out_valid",      32'(a_out_valid), 1);
            step();
            if (i < 3) check("gap_idle_cycle_valid", 32'(a_out_valid), 0);
        end
        check("gap_sig_a", 32'(a_sig_a), 32'h22);
        check("gap_sig_b", 32'(a_sig_b), 32'hee);
        check("gap_mis",   32'(a_mis), 2);
        a_out_ready = 1'b1;
        step();
        a_out_ready = 1'b0;

        // Rotate wrap on FRAME_LEN=2
        b_start = 1'b1;
        step();
        b_start = 1'b0;
        b_in_valid = 1'b1; b_aa = 8'h80; b_bb = 8'h00;
        step();
        check("wrap_no_early_valid", 32'(b_out_valid), 0);
        step();
        b_in_valid = 1'b0;
        check("wrap_out_valid", 32'(b_out_valid), 1);
        check("wrap_sig_a", 32'(b_sig_a), 32'h81);
        check("wrap_sig_b", 32'(b_sig_b), 32'h00);
        check("wrap_mis",   32'(b_mis), 2);

        // Saturation with CNT_W=2
        c_start = 1'b1;
        step();
        c_start = 1'b0;
        c_in_valid = 1'b1; c_aa = 8'hAA; c_bb = 8'h55;
        for (int i = 0; i < 4; i++) step();
        c_in_valid = 1'b0;
        check("sat_out_valid", 32'(c_out_valid), 1);
        check("sat_mis",       32'(c_mis), 3);
        check("sat_sig_a",     32'(c_sig_a), 32'h00);
        check("sat_sig_b",     32'(c_sig_b), 32'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
